neuron_nin_pipe: RTL

NEURON_NIN_PIPE -- requirements
Module: neuron_nin_pipe

---
 rtl/neuron_nin_pipe.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/neuron_nin_pipe.sv
// Event-driven integrate-and-fire neuron: per-channel decaying traces, a two-stage
// multiply/accumulate pipeline, and an ACTIVE/REFRACT firing controller.
module neuron_nin_pipe #(
    parameter int P_N            = 8,
    parameter int P_IW           = 9,
    parameter int P_WW           = 9,
    parameter int P_DECAY_SHIFT  = 4,
    parameter int P_REFRACT      = 8,
    parameter int P_CLR_ON_SPIKE = 0,
    localparam int SW            = P_IW + P_WW + $clog2(P_N)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [P_N-1:0]        i_event,
    input  logic [P_N*P_WW-1:0]   i_weight,
    input  logic [SW-1:0]         i_threshold,
    input  logic                  i_spike,
    output logic [P_N*P_IW-1:0]   o_tr,
    output logic [SW-1:0]         o_sum,
    output logic [SW-1:0]         o_lv,
    output logic                  o_spike,
    output logic                  o_refractory
);

    localparam int PW = P_IW + P_WW;
    localparam int CW = $clog2(P_REFRACT + 1);
    localparam logic [0:0] ACTIVE  = 1'b0;
    localparam logic [0:0] REFRACT = 1'b1;

    logic [P_IW-1:0] tr_r     [P_N];
    logic [P_IW-1:0] tr_nxt_s [P_N];
    logic [PW-1:0]   prod_r   [P_N];
    logic [SW-1:0]   sum_s;
    logic [SW-1:0]   sum_r;
    logic [SW-1:0]   lv_r;
    logic            spike_r;
    logic [0:0]      state_r;
    logic [CW-1:0]   cnt_r;
    logic            fire_s;
    logic            clr_s;

    // Strict comparison: a sum equal to the threshold never fires.
    assign fire_s = (state_r == ACTIVE) && (sum_r > i_threshold);
    assign clr_s  = (P_CLR_ON_SPIKE != 0) && fire_s;

    // Next trace per channel; a fresh event outranks both decay and spike-clear.
    always_comb begin
        logic [P_IW-1:0] dec;
        for (int k = 0; k < P_N; k++) begin
            dec = tr_r[k] >> P_DECAY_SHIFT;
            if (dec == '0) begin
                dec = {{(P_IW-1){1'b0}}, 1'b1};
            end else begin
                dec = dec;
            end
            if (i_event[k]) begin
                tr_nxt_s[k] = {P_IW{1'b1}};
            end else if (clr_s) begin
                tr_nxt_s[k] = '0;
            end else if (tr_r[k] != '0) begin
                tr_nxt_s[k] = tr_r[k] - dec;
            end else begin
                tr_nxt_s[k] = '0;
            end
        end
    end

    // Adder tree over the registered products; SW leaves room for every carry.
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < P_N; k++) begin
            sum_s = sum_s + SW'(prod_r[k]);
        end
    end

    // Pack traces onto the flat output bus.
    always_comb begin
        o_tr = '0;
        for (int k = 0; k < P_N; k++) begin
            o_tr[k*P_IW +: P_IW] = tr_r[k];
        end
    end

    // Traces, product stage, and sum stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < P_N; k++) begin
                tr_r[k]   <= '0;
                prod_r[k] <= '0;
            end
            sum_r <= '0;
        end else begin
            for (int k = 0; k < P_N; k++) begin
                tr_r[k]   <= tr_nxt_s[k];
                prod_r[k] <= PW'(tr_r[k]) * PW'(i_weight[k*P_WW +: P_WW]);
            end
            sum_r <= sum_s;
        end
    end

    // Firing controller: refractory down-counter, spike pulse, latched value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ACTIVE;
            cnt_r   <= '0;
            spike_r <= 1'b0;
            lv_r    <= '0;
        end else begin
            spike_r <= fire_s;
            if (fire_s || i_spike) begin
                lv_r <= sum_r;
            end else begin
                lv_r <= lv_r;
            end
            case (state_r)
                ACTIVE: begin
                    if (fire_s) begin
                        state_r <= REFRACT;
                        cnt_r   <= CW'(P_REFRACT);
                    end else begin
                        state_r <= ACTIVE;
                        cnt_r   <= '0;
                    end
                end
                REFRACT: begin
                    if (cnt_r <= CW'(1)) begin
                        state_r <= ACTIVE;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= REFRACT;
                        cnt_r   <= cnt_r - CW'(1);
                    end
                end
                default: begin
                    state_r <= ACTIVE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign o_sum        = sum_r;
    assign o_lv         = lv_r;
    assign o_spike      = spike_r;
    assign o_refractory = (state_r == REFRACT);

endmodule
